usb_protocol_fsm: RTL and testbench

//  Transaction-layer FSM between the read/write FSM (upstream) and the packet encoder/decoder (downstream).

---
 rtl/usb_pkg.sv | 54 +++++
 rtl/usb_timeout_ctr.sv | 33 +++
 rtl/usb_protocol_fsm.sv | 176 +++++++++++++++++
 tb/tb_usb_protocol_fsm.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types for the USB transaction-layer FSM: PIDs, FSM states and
// per-state packet helpers.
package usb_pkg;

  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int MAX_RETRY_DEF   = 8;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_OUT_TOK  = 4'd1,
    ST_OUT_DATA = 4'd2,
    ST_OUT_WAIT = 4'd3,
    ST_IN_TOK   = 4'd4,
    ST_IN_WAIT  = 4'd5,
    ST_IN_ACK   = 4'd6,
    ST_IN_NAK   = 4'd7,
    ST_FAIL     = 4'd8
  } state_t;

  // PID the encoder must send while the FSM sits in a packet state
  function automatic pid_t pkt_pid(state_t s);
    case (s)
      ST_OUT_TOK:  return PID_OUT;
      ST_OUT_DATA: return PID_DATA0;
      ST_IN_TOK:   return PID_IN;
      ST_IN_ACK:   return PID_ACK;
      ST_IN_NAK:   return PID_NAK;
      default:     return PID_OUT;
    endcase
  endfunction

  function automatic logic is_pkt_state(state_t s);
    case (s)
      ST_OUT_TOK, ST_OUT_DATA, ST_IN_TOK, ST_IN_ACK, ST_IN_NAK: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_wait_state(state_t s);
    case (s)
      ST_OUT_WAIT, ST_IN_WAIT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usb_timeout_ctr.sv
// Response timeout counter: cleared on entry to a wait state, counts while
// enabled and saturates at TIMEOUT_CYC.
module usb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_r;

  // Saturating cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == CNT_MAX);

endmodule

// File: rtl/usb_protocol_fsm.sv
// USB transaction-layer FSM: runs one OUT or IN transaction per request,
// retrying on NAK, receive error or timeout up to MAX_RETRY attempts.
module usb_protocol_fsm
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_in,
  input  logic        input_ready,
  input  logic [6:0]  addr,
  input  logic [3:0]  endp,
  input  logic [63:0] data_down_pro,
  output logic        free,
  output logic        bad,
  output logic        recv_ready_pro,
  output logic [63:0] data_up_pro,
  output logic        tx_start,
  output logic [3:0]  tx_pid,
  output logic [6:0]  tx_addr,
  output logic [3:0]  tx_endp,
  output logic [63:0] tx_data,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_error
);

  localparam int ATT_W = $clog2(MAX_RETRY + 1);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_RETRY);

  state_t            state_r, next_state_s;
  logic              send_r;
  logic [6:0]        addr_r;
  logic [3:0]        endp_r;
  logic [63:0]       data_r;
  logic [ATT_W-1:0]  attempts_r;

  logic              accept_s, retry_ok_s, expired_s, to_wait_s;
  logic              rx_ack_s, rx_nak_s, rx_data0_s;
  logic [ATT_W-1:0]  attempts_inc_s;

  logic              free_s, bad_s, tx_start_s, recv_ready_s;
  logic [3:0]        tx_pid_s, tx_endp_s;
  logic [6:0]        tx_addr_s;
  logic [63:0]       tx_data_s, data_up_s;

  assign accept_s       = (state_r == ST_IDLE) && input_ready;
  assign attempts_inc_s = attempts_r + ATT_W'(1);
  assign retry_ok_s     = attempts_inc_s < ATT_MAX;
  assign rx_ack_s       = rx_valid && !rx_error && (rx_pid == PID_ACK);
  assign rx_nak_s       = rx_valid && !rx_error && (rx_pid == PID_NAK);
  assign rx_data0_s     = rx_valid && !rx_error && (rx_pid == PID_DATA0);
  assign to_wait_s      = is_wait_state(next_state_s) && !is_wait_state(state_r);

  usb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_wait_s),
    .enable  (is_wait_state(state_r)),
    .expired (expired_s)
  );

  // State register plus request latch and attempt counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      send_r     <= 1'b0;
      addr_r     <= 7'd0;
      endp_r     <= 4'd0;
      data_r     <= 64'd0;
      attempts_r <= {ATT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        send_r     <= send_in;
        addr_r     <= addr;
        endp_r     <= endp;
        data_r     <= data_down_pro;
        attempts_r <= {ATT_W{1'b0}};
      end else if (state_r == ST_FAIL) begin
        attempts_r <= attempts_inc_s;
      end else begin
        attempts_r <= attempts_r;
      end
    end
  end

  // Next-state logic; a response in the expiry cycle takes priority
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:     if (input_ready) next_state_s = send_in ? ST_IN_TOK : ST_OUT_TOK;
                   else next_state_s = ST_IDLE;
      ST_OUT_TOK:  if (tx_done) next_state_s = ST_OUT_DATA; else next_state_s = ST_OUT_TOK;
      ST_OUT_DATA: if (tx_done) next_state_s = ST_OUT_WAIT; else next_state_s = ST_OUT_DATA;
      ST_OUT_WAIT: begin
        if (rx_valid) next_state_s = rx_ack_s ? ST_IDLE : ST_FAIL;
        else if (expired_s) next_state_s = ST_FAIL;
        else next_state_s = ST_OUT_WAIT;
      end
      ST_IN_TOK:   if (tx_done) next_state_s = ST_IN_WAIT; else next_state_s = ST_IN_TOK;
      ST_IN_WAIT: begin
        if (rx_data0_s) next_state_s = ST_IN_ACK;
        else if (rx_nak_s) next_state_s = ST_FAIL;
        else if (rx_valid) next_state_s = ST_IN_NAK;
        else if (expired_s) next_state_s = ST_FAIL;
        else next_state_s = ST_IN_WAIT;
      end
      ST_IN_ACK:   if (tx_done) next_state_s = ST_IDLE; else next_state_s = ST_IN_ACK;
      ST_IN_NAK:   if (tx_done) next_state_s = ST_FAIL; else next_state_s = ST_IN_NAK;
      ST_FAIL:     if (retry_ok_s) next_state_s = send_r ? ST_IN_TOK : ST_OUT_TOK;
                   else next_state_s = ST_IDLE;
      default:     next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; tx_* change only on packet entry
  always_comb begin
    free_s     = (next_state_s == ST_IDLE);
    bad_s      = (state_r == ST_FAIL) && !retry_ok_s;
    tx_start_s = is_pkt_state(next_state_s) && (next_state_s != state_r);
    if (tx_start_s) begin
      tx_pid_s  = pkt_pid(next_state_s);
      tx_addr_s = accept_s ? addr : addr_r;
      tx_endp_s = accept_s ? endp : endp_r;
      tx_data_s = accept_s ? data_down_pro : data_r;
    end else begin
      tx_pid_s  = tx_pid;
      tx_addr_s = tx_addr;
      tx_endp_s = tx_endp;
      tx_data_s = tx_data;
    end
    if (accept_s) begin
      recv_ready_s = 1'b0;
    end else if ((state_r == ST_IN_ACK) && tx_done) begin
      recv_ready_s = 1'b1;
    end else begin
      recv_ready_s = recv_ready_pro;
    end
    if ((state_r == ST_IN_WAIT) && rx_data0_s) begin
      data_up_s = rx_data;
    end else begin
      data_up_s = data_up_pro;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      free           <= 1'b1;
      bad            <= 1'b0;
      recv_ready_pro <= 1'b0;
      data_up_pro    <= 64'd0;
      tx_start       <= 1'b0;
      tx_pid         <= 4'd0;
      tx_addr        <= 7'd0;
      tx_endp        <= 4'd0;
      tx_data        <= 64'd0;
    end else begin
      free           <= free_s;
      bad            <= bad_s;
      recv_ready_pro <= recv_ready_s;
      data_up_pro    <= data_up_s;
      tx_start       <= tx_start_s;
      tx_pid         <= tx_pid_s;
      tx_addr        <= tx_addr_s;
      tx_endp        <= tx_endp_s;
      tx_data        <= tx_data_s;
    end
  end

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// Self-checking bench for usb_protocol_fsm: a table of transactions with
// scripted device behaviour, plus hand-written reset and late-response cases.
module tb_usb_protocol_fsm;

  localparam int TIMEOUT_CYC = 255;
  localparam int MAX_RETRY   = 8;
  localparam int BUDGET      = 600;

  localparam int K_NAK = 0;
  localparam int K_ERR = 1;
  localparam int K_OTHER = 2;
  localparam int K_TMO = 3;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_DATA0 = 4'b0011,
                         P_ACK = 4'b0010, P_NAK = 4'b1010;

  typedef struct {
    bit          send_in;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    int          n_fail;
    int          kind;
  } vec_t;

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    bit          tok;
    bit          dat;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst, send_in, input_ready, tx_done, rx_valid, rx_error;
  logic [6:0]  addr;
  logic [3:0]  endp, rx_pid;
  logic [63:0] data_down_pro, rx_data;
  logic        free, bad, recv_ready_pro, tx_start;
  logic [63:0] data_up_pro, tx_data;
  logic [3:0]  tx_pid, tx_endp;
  logic [6:0]  tx_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bad_cnt = 0;
  int last_done_cyc = 0;
  int last_start_cyc = 0;
  pkt_t exp_q[$];
  vec_t vecs[8];

  usb_protocol_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .send_in(send_in), .input_ready(input_ready),
    .addr(addr), .endp(endp), .data_down_pro(data_down_pro),
    .free(free), .bad(bad), .recv_ready_pro(recv_ready_pro), .data_up_pro(data_up_pro),
    .tx_start(tx_start), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
    .tx_data(tx_data), .tx_done(tx_done), .rx_valid(rx_valid), .rx_pid(rx_pid),
    .rx_data(rx_data), .rx_error(rx_error)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;
  always_ff @(negedge clk) if (bad) bad_cnt <= bad_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic pkt_t mk(input logic [3:0] pid, input bit tok, input bit dat,
                              input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
    pkt_t p;
    p.pid = pid; p.tok = tok; p.dat = dat; p.addr = a; p.endp = e; p.data = d;
    return p;
  endfunction

  // Wait for the next packet, compare with the scoreboard head, then complete it
  task automatic get_pkt(input string name);
    pkt_t e;
    int n = 0;
    while (tx_start !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    if (exp_q.size() == 0) begin
      chk({name, ".unexpected"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    if (n >= BUDGET) begin
      chk({name, ".tx_start_timeout"}, 64'd0, 64'd1);
      return;
    end
    last_start_cyc = cyc;
    chk({name, ".pid"}, tx_pid, e.pid);
    if (e.tok) begin
      chk({name, ".addr"}, tx_addr, e.addr);
      chk({name, ".endp"}, tx_endp, e.endp);
    end
    if (e.dat) chk({name, ".data"}, tx_data, e.data);
    tick();
    chk({name, ".start_pulse"}, tx_start, 1'b0);
    chk({name, ".pid_stable"}, tx_pid, e.pid);
    tx_done = 1'b1;
    last_done_cyc = cyc;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic pulse_rx(input logic [3:0] pid, input logic err, input logic [63:0] d);
    rx_valid = 1'b1; rx_pid = pid; rx_error = err; rx_data = d;
    tick();
    rx_valid = 1'b0; rx_error = 1'b0; rx_pid = 4'd0; rx_data = 64'd0;
  endtask

  task automatic request(input bit si, input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
    int n = 0;
    while (free !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    chk("free_before_accept", free, 1'b1);
    send_in = si; addr = a; endp = e; data_down_pro = d; input_ready = 1'b1;
    tick();
    input_ready = 1'b0; send_in = ~si; addr = ~a; endp = ~e; data_down_pro = ~d;
    chk("free_after_accept", free, 1'b0);
    chk("recv_ready_cleared", recv_ready_pro, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int bad0 = bad_cnt;
    int wait_done = 0;
    bit gap_pending = 1'b0;
    int n;
    string tag = $sformatf("v%0d", idx);
    request(v.send_in, v.addr, v.endp, v.data);
    for (int a = 0; a < MAX_RETRY; a++) begin
      exp_q.push_back(mk(v.send_in ? P_IN : P_OUT, 1'b1, 1'b0, v.addr, v.endp, 64'd0));
      get_pkt({tag, ".tok"});
      if (gap_pending) chk_range({tag, ".retry_gap"}, last_start_cyc - wait_done,
                                 TIMEOUT_CYC + 1, TIMEOUT_CYC + 4);
      gap_pending = 1'b0;
      if (!v.send_in) begin
        exp_q.push_back(mk(P_DATA0, 1'b0, 1'b1, 7'd0, 4'd0, v.data));
        get_pkt({tag, ".data0"});
      end
      if (a < v.n_fail) begin
        wait_done = last_done_cyc;
        case (v.kind)
          K_NAK:   pulse_rx(P_NAK, 1'b0, 64'd0);
          K_ERR:   pulse_rx(v.send_in ? P_DATA0 : P_ACK, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
          K_OTHER: pulse_rx(v.send_in ? P_ACK : P_DATA0, 1'b0, 64'd0);
          default: gap_pending = 1'b1;
        endcase
        if (v.send_in && (v.kind == K_ERR || v.kind == K_OTHER)) begin
          exp_q.push_back(mk(P_NAK, 1'b0, 1'b0, 7'd0, 4'd0, 64'd0));
          get_pkt({tag, ".nak"});
        end
        if (a == MAX_RETRY - 1) begin
          n = 0;
          while (bad !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
          end
          chk({tag, ".bad_seen"}, bad, 1'b1);
          if (v.kind == K_TMO) chk_range({tag, ".bad_gap"}, cyc - wait_done,
                                         TIMEOUT_CYC + 1, TIMEOUT_CYC + 4);
          chk({tag, ".free_with_bad"}, free, 1'b1);
          tick();
          chk({tag, ".bad_one_cycle"}, bad, 1'b0);
          chk({tag, ".recv_ready_after_bad"}, recv_ready_pro, 1'b0);
          chk({tag, ".bad_count"}, bad_cnt - bad0, 1);
        end
      end else begin
        if (v.send_in) begin
          pulse_rx(P_DATA0, 1'b0, v.data);
          exp_q.push_back(mk(P_ACK, 1'b0, 1'b0, 7'd0, 4'd0, 64'd0));
          get_pkt({tag, ".ack"});
          chk({tag, ".free_done"}, free, 1'b1);
          chk({tag, ".recv_ready"}, recv_ready_pro, 1'b1);
          chk({tag, ".data_up"}, data_up_pro, v.data);
          repeat (5) tick();
          chk({tag, ".data_up_held"}, data_up_pro, v.data);
          chk({tag, ".recv_ready_held"}, recv_ready_pro, 1'b1);
        end else begin
          pulse_rx(P_ACK, 1'b0, 64'd0);
          chk({tag, ".free_done"}, free, 1'b1);
        end
        chk({tag, ".no_bad"}, bad_cnt - bad0, 0);
        break;
      end
    end
  endtask

  initial begin
    int bad0;
    vecs[0] = '{send_in:1'b0, addr:7'd5,  endp:4'd4, data:64'h1234,                n_fail:0, kind:K_NAK};
    vecs[1] = '{send_in:1'b1, addr:7'd5,  endp:4'd8, data:64'hDEADBEEF_CAFEF00D,   n_fail:0, kind:K_NAK};
    vecs[2] = '{send_in:1'b0, addr:7'h12, endp:4'h1, data:64'hA5A5_0000_FFFF_1357, n_fail:3, kind:K_NAK};
    vecs[3] = '{send_in:1'b1, addr:7'h7F, endp:4'hF, data:64'h0123_4567_89AB_CDEF, n_fail:1, kind:K_ERR};
    vecs[4] = '{send_in:1'b0, addr:7'h40, endp:4'h7, data:64'hFEDC_BA98_7654_3210, n_fail:1, kind:K_ERR};
    vecs[5] = '{send_in:1'b1, addr:7'h01, endp:4'h2, data:64'h5555_AAAA_3333_CCCC, n_fail:2, kind:K_OTHER};
    vecs[6] = '{send_in:1'b0, addr:7'h22, endp:4'h5, data:64'h0F0F_0F0F_1111_2222, n_fail:1, kind:K_TMO};
    vecs[7] = '{send_in:1'b1, addr:7'd5,  endp:4'd8, data:64'h0,                   n_fail:8, kind:K_TMO};

    rst = 1'b1; send_in = 1'b0; input_ready = 1'b0; addr = 7'd0; endp = 4'd0;
    data_down_pro = 64'd0; tx_done = 1'b0; rx_valid = 1'b0; rx_pid = 4'd0;
    rx_data = 64'd0; rx_error = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst.free", free, 1'b1);
    chk("rst.bad", bad, 1'b0);
    chk("rst.recv_ready", recv_ready_pro, 1'b0);
    chk("rst.data_up", data_up_pro, 64'd0);
    chk("rst.tx_start", tx_start, 1'b0);
    chk("rst.tx_pid", tx_pid, 4'd0);
    chk("rst.tx_addr", tx_addr, 7'd0);
    chk("rst.tx_data", tx_data, 64'd0);
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset while DATA0 is being sent: clean abort, no bad
    bad0 = bad_cnt;
    request(1'b0, 7'd3, 4'd2, 64'h7777);
    exp_q.push_back(mk(P_OUT, 1'b1, 1'b0, 7'd3, 4'd2, 64'd0));
    get_pkt("rstmid.tok");
    chk("rstmid.data0_start", tx_start, 1'b1);
    chk("rstmid.data0_pid", tx_pid, P_DATA0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.free", free, 1'b1);
    chk("rstmid.tx_start", tx_start, 1'b0);
    chk("rstmid.bad", bad, 1'b0);
    repeat (3) tick();
    chk("rstmid.no_bad", bad_cnt - bad0, 0);
    run_vec(vecs[0], 10);

    // ACK arriving TIMEOUT_CYC cycles after DATA0; a request while busy is ignored
    bad0 = bad_cnt;
    request(1'b0, 7'd9, 4'd3, 64'hC0DE);
    exp_q.push_back(mk(P_OUT, 1'b1, 1'b0, 7'd9, 4'd3, 64'd0));
    get_pkt("late.tok");
    exp_q.push_back(mk(P_DATA0, 1'b0, 1'b1, 7'd0, 4'd0, 64'hC0DE));
    get_pkt("late.data0");
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      input_ready = (i == 10);
      send_in = 1'b1; addr = 7'h55;
      tick();
    end
    input_ready = 1'b0;
    chk("late.busy", free, 1'b0);
    pulse_rx(P_ACK, 1'b0, 64'd0);
    chk("late.free", free, 1'b1);
    chk("late.no_bad", bad_cnt - bad0, 0);
    tick();
    chk("late.idle_no_tx", tx_start, 1'b0);

    run_vec(vecs[7], 7);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
